matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, element width; N, default 3, matrix dimension (N*N elements per matrix).
REQ-002 SHALL have ports:
- CLK  input  1  single clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-low.
- start_i  input  1  begin a load sequence.
- din  input  DATA_W  stream data.
- din_valid  input  1  din holds a valid element.
- din_ready  output  1  loader accepts din this cycle.
- WRITE_EN_A  output  1  write strobe, matrix A store.
- WRITE_EN_B  output  1  write strobe, matrix B store.
- wr_addr  output  4  element index, row-major, 0..N*N-1.
- wr_data  output  DATA_W  element being written.
- go_o  output  1  one-cycle start pulse to the multiplier controller.
- loaded  output  1  both matrices written and go issued.
- busy  output  1  load sequence in progress.
- err  output  1  checksum mismatch (macro-dependent, REQ-019).

Function
REQ-003 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, CHECK, GO, DONE.
REQ-004 IDLE: start_i=1 -> LOAD_A, element counter cleared to 0, loaded and err cleared.
REQ-005 Transfer SHALL occur only in a cycle where din_valid=1 and din_ready=1.
REQ-006 din_ready SHALL be 1 only in LOAD_A, LOAD_B, CHECK; 0 in every other state.
REQ-007 On transfer in LOAD_A: WRITE_EN_A=1, wr_addr=counter, wr_data=din, same cycle (combinational, zero latency); counter increments.
REQ-008 On transfer in LOAD_B: WRITE_EN_B=1, identical addressing.
REQ-009 WRITE_EN_A and WRITE_EN_B SHALL never be 1 in the same cycle and SHALL be 0 whenever no transfer occurs.
REQ-010 Transfer of element N*N-1 in LOAD_A -> LOAD_B, counter wraps to 0 in the same edge.
REQ-011 Transfer of element N*N-1 in LOAD_B -> CHECK if LOADER_CHECKSUM_EN defined, else -> GO.
REQ-012 din_valid=0 in a load state: state and counter hold; no write; no timeout.
REQ-013 GO: go_o=1 for exactly one cycle, then -> DONE; go_o=0 in all other states.
REQ-014 DONE: loaded=1; start_i=1 -> LOAD_A (reload, REQ-004 applies); otherwise hold.
REQ-015 start_i SHALL be ignored in LOAD_A, LOAD_B, CHECK, GO.
REQ-016 busy SHALL be 1 in LOAD_A, LOAD_B, CHECK, GO; 0 in IDLE, DONE.
REQ-017 Counter width SHALL be 4 bits; N*N SHALL not exceed 16.

Reset
REQ-018 RST=0 sampled on a CLK edge SHALL force IDLE, counter=0, checksum=0, go_o=0, loaded=0, err=0, busy=0, din_ready=0, both write strobes 0, wr_addr=0, wr_data=0, regardless of state, including mid-load; partially written store contents are not cleared.

Configuration
REQ-019 Macro LOADER_CHECKSUM_EN:
- defined: 8-bit modulo-256 sum of all 2*N*N transferred elements accumulates; in CHECK one extra transfer (no write strobe) is compared with the sum; equal -> GO; unequal -> err=1, -> IDLE, no go_o; err holds until next start_i or reset.
- undefined: no accumulator, no CHECK state reachable, err tied 0.

Structure
REQ-020 Shared package SHALL hold the state enumeration, N default, and the address width constant, shared with the multiplier FSM controller.
REQ-021 Counter SHALL be a sub-module elem_counter (clear, enable, wrap at N*N-1, terminal-count flag); remainder is one module.

Verification
REQ-022 Scenarios:
- Reset, start_i=1, stream 1..18 back-to-back -> A[0..8]=1..9, B[0..8]=10..18, go_o single pulse, loaded=1, 20 cycles from start to DONE.
- Same stream with din_valid low every other cycle -> identical store contents, no extra writes, go_o after the 18th transfer only.
- RST=0 after 5 A elements -> next cycle IDLE, all outputs 0; new start_i then writes from A[0].
- start_i pulsed during LOAD_B -> ignored, sequence completes normally.
- LOADER_CHECKSUM_EN, elements 1..18 then 171 (sum=171) -> go_o, loaded=1; then 170 -> err=1, no go_o, IDLE.
- DONE then start_i=1 with stream of 0xFF -> loaded drops, all 18 locations rewritten 0xFF, loaded=1 again.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg
// Shared definitions for the matrix loader and the multiplier FSM controller:
// the loader state enumeration, the default matrix dimension and the element
// address width. A couple of state-decode helpers live here so every user of
// the enumeration classifies states the same way.
//   N_DEFAULT  default matrix dimension (N*N elements per matrix)
//   ADDR_W     element address / counter width (N*N must not exceed 16)
package matrix_loader_pkg;

  localparam int N_DEFAULT = 3;
  localparam int ADDR_W    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    GO     = 3'd4,
    DONE   = 3'd5
  } state_t;

  // States in which the loader accepts stream data.
  function automatic logic isLoadState(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == CHECK);
  endfunction

  // States that make up an active load sequence.
  function automatic logic isBusyState(input state_t s);
    return isLoadState(s) || (s == GO);
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if
// Bundles the stream handshake, the two store write ports and the status
// signals of the matrix loader.
//   master modport : stream source / store / controller side
//   slave  modport : the loader itself
//   start_i, din, din_valid            -> loader
//   din_ready, WRITE_EN_A, WRITE_EN_B,
//   wr_addr, wr_data, go_o, loaded,
//   busy, err                          <- loader
interface matrix_loader_if
  import matrix_loader_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic              start_i;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              WRITE_EN_A;
  logic              WRITE_EN_B;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              go_o;
  logic              loaded;
  logic              busy;
  logic              err;

  modport master (
    output start_i, din, din_valid,
    input  din_ready, WRITE_EN_A, WRITE_EN_B, wr_addr, wr_data,
    input  go_o, loaded, busy, err
  );

  modport slave (
    input  start_i, din, din_valid,
    output din_ready, WRITE_EN_A, WRITE_EN_B, wr_addr, wr_data,
    output go_o, loaded, busy, err
  );

endinterface

// File: rtl/elem_counter.sv
// elem_counter
// Row-major element index counter for the matrix loader. Counts 0..N*N-1 and
// wraps back to 0 on the increment after the last element.
//   CLK       clock, rising edge
//   RST       synchronous reset, active low
//   i_clear   force the count to 0 (priority over i_enable)
//   i_enable  advance the count by one
//   o_count   current element index
//   o_tc      terminal count: o_count is the last element N*N-1
module elem_counter
  import matrix_loader_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

  logic [ADDR_W-1:0] r_count;

  // Clear wins over enable so a restart always begins at element 0.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader
// Streams 2*N*N elements into the A store then the B store (row-major), then
// issues a one-cycle go pulse to the multiplier controller and reports loaded.
//   CLK   clock, rising edge
//   RST   synchronous reset, active low
//   bus   matrix_loader_if.slave: stream input, store write ports, status
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a modulo-256 sum of all loaded elements is kept and one extra
//   stream word received in CHECK must equal it; a mismatch raises err and
//   returns to IDLE without a go pulse. When undefined, err is tied low.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = N_DEFAULT
) (
  input logic            CLK,
  input logic            RST,
  matrix_loader_if.slave bus
);

  state_t r_state;
  state_t w_nextState;
  logic   r_dinReady;
  logic   r_busy;
  logic   r_goO;
  logic   r_loaded;

  logic              w_transfer;
  logic              w_writeA;
  logic              w_writeB;
  logic              w_startLoad;
  logic              w_lastElem;
  logic [ADDR_W-1:0] w_count;
  logic [DATA_W-1:0] w_wrData;

  // Gating with RST keeps the stores untouched in a cycle where reset is held.
  assign w_transfer  = RST && bus.din_valid && r_dinReady;
  assign w_writeA    = w_transfer && (r_state == LOAD_A);
  assign w_writeB    = w_transfer && (r_state == LOAD_B);
  assign w_startLoad = bus.start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_wrData    = (w_writeA || w_writeB) ? bus.din : '0;

  elem_counter #(
    .N (N)
  ) u_elemCounter (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (w_startLoad),
    .i_enable (w_writeA || w_writeB),
    .o_count  (w_count),
    .o_tc     (w_lastElem)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;
  logic       r_err;
  logic       w_sumMatch;

  assign w_sumMatch = (8'(bus.din) == r_checksum);

  // Running sum of loaded elements; err is sticky until the next start.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_checksum <= '0;
      r_err      <= 1'b0;
    end else if (w_startLoad) begin
      r_checksum <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_writeA || w_writeB) begin
        r_checksum <= r_checksum + 8'(bus.din);
      end
      if (w_transfer && (r_state == CHECK) && !w_sumMatch) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // Next-state decode; the registered outputs below are derived from it so
  // they change on the same edge as the state.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start_i) w_nextState = LOAD_A;
      end
      LOAD_A: begin
        if (w_writeA && w_lastElem) w_nextState = LOAD_B;
      end
      LOAD_B: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_writeB && w_lastElem) w_nextState = CHECK;
`else
        if (w_writeB && w_lastElem) w_nextState = GO;
`endif
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_transfer) w_nextState = w_sumMatch ? GO : IDLE;
`else
        w_nextState = IDLE;
`endif
      end
      GO:      w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_dinReady <= 1'b0;
      r_busy     <= 1'b0;
      r_goO      <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_dinReady <= isLoadState(w_nextState);
      r_busy     <= isBusyState(w_nextState);
      r_goO      <= (w_nextState == GO);
      r_loaded   <= (w_nextState == DONE);
    end
  end

  assign bus.din_ready  = r_dinReady;
  assign bus.busy       = r_busy;
  assign bus.go_o       = r_goO;
  assign bus.loaded     = r_loaded;
  assign bus.WRITE_EN_A = w_writeA;
  assign bus.WRITE_EN_B = w_writeB;
  assign bus.wr_addr    = w_count;
  assign bus.wr_data    = w_wrData;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader
// Directed bench for matrix_loader (N=3, DATA_W=8). Expected store writes are
// queued as each element is driven and matched against the write strobes by a
// monitor; store contents and status outputs are compared against constants.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the checksum scenarios).
module tb_matrix_loader;

  typedef struct packed {
    logic       isB;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic rst;

  matrix_loader_if #(.DATA_W(8)) bus ();

  matrix_loader #(
    .DATA_W (8),
    .N      (3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  wr_t  sbq[$];
  logic [7:0] memA[16];
  logic [7:0] memB[16];
  int   writesSeen = 0;
  int   goPulses = 0;
  int   goAfterWrites = 0;
  logic [7:0] streamSum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store model and scoreboard: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    wr_t exp;
    if (bus.WRITE_EN_A || bus.WRITE_EN_B) begin
      checkOutput("single_strobe", 32'(bus.WRITE_EN_A & bus.WRITE_EN_B), 32'd0);
      checkOutput("write_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp = sbq.pop_front();
        checkOutput("wr_store_b", 32'(bus.WRITE_EN_B), 32'(exp.isB));
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(exp.addr));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(exp.data));
      end
      if (bus.WRITE_EN_A) memA[bus.wr_addr] = bus.wr_data;
      if (bus.WRITE_EN_B) memB[bus.wr_addr] = bus.wr_data;
      writesSeen++;
    end
    if (bus.go_o) begin
      goPulses++;
      goAfterWrites = writesSeen;
    end
  end

  // Streams 18 elements; optional idle gaps and a start_i pulse at one index.
  task automatic applyStimulus(input logic [7:0] base, input bit sameVal,
                               input bit gaps, input int startPulseAt);
    logic [7:0] v;
    streamSum = 8'd0;
    for (int idx = 0; idx < 18; idx++) begin
      v = sameVal ? base : base + 8'(idx);
      if (gaps) begin
        bus.din       = 8'hEE;
        bus.din_valid = 1'b0;
        tick();
      end
      bus.din       = v;
      bus.din_valid = 1'b1;
      bus.start_i   = (idx == startPulseAt);
      sbq.push_back('{isB: (idx >= 9), addr: 4'(idx % 9), data: v});
      streamSum     = streamSum + v;
      tick();
    end
    bus.din_valid = 1'b0;
    bus.start_i   = 1'b0;
  endtask

  task automatic startLoad();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checkOutput("start_busy", 32'(bus.busy), 32'd1);
    checkOutput("start_din_ready", 32'(bus.din_ready), 32'd1);
    checkOutput("start_loaded", 32'(bus.loaded), 32'd0);
    checkOutput("start_err", 32'(bus.err), 32'd0);
  endtask

  // Completes a load (checksum word when enabled) and checks GO then DONE.
  task automatic finishLoad(input int goBase, input int wrBase);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("check_din_ready", 32'(bus.din_ready), 32'd1);
    checkOutput("check_go", 32'(bus.go_o), 32'd0);
    bus.din       = streamSum;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
`endif
    checkOutput("go_pulse", 32'(bus.go_o), 32'd1);
    checkOutput("go_loaded", 32'(bus.loaded), 32'd0);
    checkOutput("go_din_ready", 32'(bus.din_ready), 32'd0);
    checkOutput("go_busy", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("done_go", 32'(bus.go_o), 32'd0);
    checkOutput("done_loaded", 32'(bus.loaded), 32'd1);
    checkOutput("done_busy", 32'(bus.busy), 32'd0);
    checkOutput("done_err", 32'(bus.err), 32'd0);
    checkOutput("go_count", 32'(goPulses - goBase), 32'd1);
    checkOutput("go_after_writes", 32'(goAfterWrites - wrBase), 32'd18);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic checkMem(input logic [7:0] base, input bit sameVal);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("memA[%0d]", k), 32'(memA[k]),
                  32'(sameVal ? base : base + 8'(k)));
      checkOutput($sformatf("memB[%0d]", k), 32'(memB[k]),
                  32'(sameVal ? base : base + 8'(k + 9)));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_din_ready"}, 32'(bus.din_ready), 32'd0);
    checkOutput({tag, "_go"}, 32'(bus.go_o), 32'd0);
    checkOutput({tag, "_loaded"}, 32'(bus.loaded), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_we_a"}, 32'(bus.WRITE_EN_A), 32'd0);
    checkOutput({tag, "_we_b"}, 32'(bus.WRITE_EN_B), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  initial begin
    int goBase;
    int wrBase;

    rst           = 1'b0;
    bus.start_i   = 1'b0;
    bus.din       = 8'h5A;
    bus.din_valid = 1'b1;

    // Reset with valid data present: nothing may be accepted or written.
    tick();
    tick();
    checkIdleOutputs("reset");
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back stream 1..18; GO lands 19 edges after start, DONE at 20.
    $display("[TB] back-to-back stream");
    goBase = goPulses;
    wrBase = writesSeen;
    startLoad();
    applyStimulus(8'd1, 1'b0, 1'b0, -1);
    finishLoad(goBase, wrBase);
    checkMem(8'd1, 1'b0);
    tick();
    tick();
    checkOutput("done_hold_loaded", 32'(bus.loaded), 32'd1);
    checkOutput("done_hold_busy", 32'(bus.busy), 32'd0);

    // Same stream with din_valid low every other cycle.
    $display("[TB] gapped stream");
    goBase = goPulses;
    wrBase = writesSeen;
    startLoad();
    applyStimulus(8'd1, 1'b0, 1'b1, -1);
    finishLoad(goBase, wrBase);
    checkMem(8'd1, 1'b0);

    // Reset after five A elements, then restart from A[0].
    $display("[TB] reset mid-load");
    startLoad();
    for (int i = 0; i < 5; i++) begin
      bus.din       = 8'h30 + 8'(i);
      bus.din_valid = 1'b1;
      sbq.push_back('{isB: 1'b0, addr: 4'(i), data: 8'h30 + 8'(i)});
      tick();
    end
    checkOutput("midload_addr", 32'(bus.wr_addr), 32'd5);
    bus.din_valid = 1'b0;
    rst           = 1'b0;
    tick();
    checkIdleOutputs("midreset");
    rst = 1'b1;
    tick();
    goBase = goPulses;
    wrBase = writesSeen;
    startLoad();
    applyStimulus(8'h40, 1'b0, 1'b0, -1);
    finishLoad(goBase, wrBase);
    checkMem(8'h40, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum word: err, back to IDLE, no go pulse.
    $display("[TB] checksum mismatch");
    goBase = goPulses;
    startLoad();
    applyStimulus(8'd1, 1'b0, 1'b0, -1);
    checkOutput("sum_value", 32'(streamSum), 32'd171);
    bus.din       = 8'd170;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    checkOutput("bad_sum_err", 32'(bus.err), 32'd1);
    checkOutput("bad_sum_busy", 32'(bus.busy), 32'd0);
    checkOutput("bad_sum_ready", 32'(bus.din_ready), 32'd0);
    checkOutput("bad_sum_loaded", 32'(bus.loaded), 32'd0);
    tick();
    checkOutput("err_hold", 32'(bus.err), 32'd1);
    checkOutput("bad_sum_no_go", 32'(goPulses - goBase), 32'd0);
`endif

    // start_i pulsed during LOAD_B must be ignored.
    $display("[TB] start during LOAD_B");
    goBase = goPulses;
    wrBase = writesSeen;
    startLoad();
    applyStimulus(8'h60, 1'b0, 1'b0, 12);
    finishLoad(goBase, wrBase);
    checkMem(8'h60, 1'b0);

    // Reload from DONE with all 0xFF.
    $display("[TB] reload from DONE");
    goBase = goPulses;
    wrBase = writesSeen;
    startLoad();
    applyStimulus(8'hFF, 1'b1, 1'b0, -1);
    finishLoad(goBase, wrBase);
    checkMem(8'hFF, 1'b1);

    tick();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
